// File: rtl/pool_controller.sv
// ReLU + 2x2/stride-2 max-pool engine: streams each N x N feature map from SDRAM
// and writes the pooled P x P map back, one pass per CPU start command.
module pool_controller #(
  parameter int DATA_W = 32,
  parameter int DIM_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              slave_waitrequest,
  input  logic [2:0]        slave_address,
  input  logic              slave_read,
  output logic [31:0]       slave_readdata,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  input  logic              master_waitrequest,
  output logic [31:0]       master_address,
  output logic              master_read,
  input  logic [DATA_W-1:0] master_readdata,
  output logic              master_write,
  output logic [DATA_W-1:0] master_writedata
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

  localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);
  localparam logic [DIM_W-1:0] DIM_TWO = DIM_W'(2);

  state_t              state_q, state_d;
  logic [31:0]         start_q, in_base_q, out_base_q;
  logic [DIM_W-1:0]    map_cnt_q, row_len_q;
  logic [DIM_W-1:0]    m_q, m_d, r_q, r_d, c_q, c_d;
  logic [1:0]          k_q, k_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                done_q, done_d;
  logic                mrd_q, mrd_d, mwr_q, mwr_d;
  logic [31:0]         maddr_q, maddr_d;
  logic [DATA_W-1:0]   mwdata_q, mwdata_d;
  logic                cfg_we_s, start_s, busy_s;
  logic [DIM_W-1:0]    p_s;

  function automatic logic [31:0] rd_word(input logic [31:0] base, input logic [DIM_W-1:0] n,
                                          input logic [DIM_W-1:0] m, input logic [DIM_W-1:0] r,
                                          input logic [DIM_W-1:0] c, input logic [1:0] k);
    logic [31:0] n_w, row_w, col_w;
    n_w   = 32'(n);
    row_w = 32'(r) * 32'd2 + 32'(k[1]);
    col_w = 32'(c) * 32'd2 + 32'(k[0]);
    return base + 32'(m) * n_w * n_w + row_w * n_w + col_w;
  endfunction

  function automatic logic [31:0] wr_word(input logic [31:0] base, input logic [DIM_W-1:0] p,
                                          input logic [DIM_W-1:0] m, input logic [DIM_W-1:0] r,
                                          input logic [DIM_W-1:0] c);
    logic [31:0] p_w;
    p_w = 32'(p);
    return base + 32'(m) * p_w * p_w + 32'(r) * p_w + 32'(c);
  endfunction

  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] a);
    return a[DATA_W-1] ? {DATA_W{1'b0}} : a;
  endfunction

  assign busy_s   = (state_q != S_IDLE);
  assign cfg_we_s = slave_write && !busy_s;
  assign start_s  = cfg_we_s && (slave_address == 3'd0);
  assign p_s      = row_len_q >> 1;

  // CPU-visible configuration registers; frozen while a pass is running
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q    <= 32'd0;
      in_base_q  <= 32'd0;
      out_base_q <= 32'd0;
      map_cnt_q  <= {DIM_W{1'b0}};
      row_len_q  <= {DIM_W{1'b0}};
    end else if (cfg_we_s) begin
      case (slave_address)
        3'd0:    start_q    <= slave_writedata;
        3'd1:    in_base_q  <= slave_writedata;
        3'd2:    out_base_q <= slave_writedata;
        3'd3:    map_cnt_q  <= slave_writedata[DIM_W-1:0];
        3'd4:    row_len_q  <= slave_writedata[DIM_W-1:0];
        default: ;
      endcase
    end
  end

  // Sequencer: window counters, accumulator and done flag
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    r_d     = r_q;
    c_d     = c_q;
    k_d     = k_q;
    acc_d   = acc_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          done_d = 1'b0;
          m_d    = {DIM_W{1'b0}};
          r_d    = {DIM_W{1'b0}};
          c_d    = {DIM_W{1'b0}};
          k_d    = 2'd0;
          if (map_cnt_q == {DIM_W{1'b0}} || row_len_q < DIM_TWO) state_d = S_FIN;
          else state_d = S_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (!master_waitrequest) begin
          if (k_q == 2'd0) acc_d = master_readdata;
          else if ($signed(master_readdata) > $signed(acc_q)) acc_d = master_readdata;
          else acc_d = acc_q;
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) state_d = S_WR;
          else state_d = S_RD;
        end else begin
          state_d = S_RD;
        end
      end
      S_WR: begin
        if (!master_waitrequest) begin
          state_d = S_RD;
          if (c_q == p_s - DIM_ONE) begin
            c_d = {DIM_W{1'b0}};
            if (r_q == p_s - DIM_ONE) begin
              r_d = {DIM_W{1'b0}};
              if (m_q == map_cnt_q - DIM_ONE) state_d = S_FIN;
              else m_d = m_q + DIM_ONE;
            end else begin
              r_d = r_q + DIM_ONE;
            end
          end else begin
            c_d = c_q + DIM_ONE;
          end
        end else begin
          state_d = S_WR;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Master bus outputs are derived from the next state so they register cleanly and hold while stalled
  always_comb begin
    mrd_d    = (state_d == S_RD);
    mwr_d    = (state_d == S_WR);
    maddr_d  = 32'd0;
    mwdata_d = {DATA_W{1'b0}};
    if (state_d == S_RD) maddr_d = rd_word(in_base_q, row_len_q, m_d, r_d, c_d, k_d) << 2;
    else if (state_d == S_WR) maddr_d = wr_word(out_base_q, p_s, m_d, r_d, c_d) << 2;
    else maddr_d = 32'd0;
    if (state_q == S_RD && state_d == S_WR) mwdata_d = relu(acc_d);
    else if (state_d == S_WR) mwdata_d = mwdata_q;
    else mwdata_d = {DATA_W{1'b0}};
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      m_q      <= {DIM_W{1'b0}};
      r_q      <= {DIM_W{1'b0}};
      c_q      <= {DIM_W{1'b0}};
      k_q      <= 2'd0;
      acc_q    <= {DATA_W{1'b0}};
      done_q   <= 1'b0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
      maddr_q  <= 32'd0;
      mwdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      r_q      <= r_d;
      c_q      <= c_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      done_q   <= done_d;
      mrd_q    <= mrd_d;
      mwr_q    <= mwr_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  // Register read mux
  always_comb begin
    slave_readdata = 32'd0;
    if (slave_read) begin
      case (slave_address)
        3'd0:    slave_readdata = start_q;
        3'd1:    slave_readdata = in_base_q;
        3'd2:    slave_readdata = out_base_q;
        3'd3:    slave_readdata = 32'(map_cnt_q);
        3'd4:    slave_readdata = 32'(row_len_q);
        3'd5:    slave_readdata = {30'd0, done_q, busy_s};
        default: slave_readdata = 32'd0;
      endcase
    end else begin
      slave_readdata = 32'd0;
    end
  end

  assign slave_waitrequest = 1'b0;
  assign master_read       = mrd_q;
  assign master_write      = mwr_q;
  assign master_address    = maddr_q;
  assign master_writedata  = mwdata_q;

endmodule
